// File: rtl/game_state_engine.sv
// Frame-rate Flappy Bird game logic: bird physics, pipe scrolling/recycling,
// scoring and collision detection feeding game_render_controller.
module game_state_engine #(
  parameter int unsigned FRAME_DIV    = 833333,
  parameter int          GRAVITY      = 1,
  parameter int          FLAP_V       = 7,
  parameter int          MAX_FALL     = 8,
  parameter int          PIPE_SPEED   = 2,
  parameter int          PIPE_SPACING = 240,
  parameter int          PIPE_W       = 52,
  parameter int          GAP_H        = 120,
  parameter int          GAP_MIN      = 60,
  parameter int          BIRD_X       = 100,
  parameter int          BIRD_W       = 34,
  parameter int          BIRD_H       = 24,
  parameter int          GROUND_Y     = 400,
  parameter int          INIT_Y       = 216,
  parameter int          FIRST_X      = 640
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic [1:0]         iScreen,
  input  logic               iFlap,
  input  logic [31:0]        iRandom,
  output logic [9:0]         oBirdY,
  output logic signed [10:0] oPipe1X,
  output logic signed [10:0] oPipe2X,
  output logic signed [10:0] oPipe3X,
  output logic [9:0]         oPipe1Y,
  output logic [9:0]         oPipe2Y,
  output logic [9:0]         oPipe3Y,
  output logic [9:0]         oScore,
  output logic               oGameOver,
  output logic               oFrameTick
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_e;

  localparam int unsigned   NP        = 3;
  localparam int unsigned   CW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_DIV - 1);
  localparam int            SCORE_MAX = 999;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               flap_q, flap_d;
  logic signed [7:0]  vel_q, vel_d;
  logic [9:0]         bird_y_q, bird_y_d;
  // One bit wider than the port so the 1120 start position stays positive;
  // the port carries the low 11 bits.
  logic signed [11:0] pipe_x_q [NP];
  logic signed [11:0] pipe_x_d [NP];
  logic [9:0]         gap_y_q [NP];
  logic [9:0]         gap_y_d [NP];
  logic [9:0]         score_q, score_d;
  logic               over_q, over_d;
  logic               tick_q, tick_d;

  logic signed [7:0]  upd_vel;
  logic [9:0]         upd_y;
  logic signed [11:0] upd_x [NP];
  logic [9:0]         upd_gap [NP];
  logic [9:0]         upd_score;
  logic               hit;
  logic               unused_rand;

  assign unused_rand = ^iRandom[31:24];

  always_comb begin : frame_update
    int v, y, x_old, x_new, sc;
    int unsigned crossed;
    v = int'(vel_q) + GRAVITY;
    if (v > MAX_FALL) v = MAX_FALL;
    if (flap_q || iFlap) v = -FLAP_V;
    y = int'(bird_y_q) + v;
    if (y < 0) begin
      y = 0;
      v = 0;
    end
    upd_vel = 8'(v);
    upd_y   = 10'(y);
    crossed = 0;
    for (int unsigned k = 0; k < NP; k++) begin
      x_old      = int'(pipe_x_q[k]);
      x_new      = x_old - PIPE_SPEED;
      if ((x_old + PIPE_W > BIRD_X) && (x_new + PIPE_W <= BIRD_X)) crossed++;
      upd_gap[k] = gap_y_q[k];
      if (x_new <= -PIPE_W) begin
        x_new      = x_new + 3 * PIPE_SPACING;
        upd_gap[k] = 10'(GAP_MIN + int'(iRandom[7:0]));
      end
      upd_x[k]   = 12'(x_new);
    end
    sc        = int'(score_q) + int'(crossed);
    upd_score = (sc > SCORE_MAX) ? 10'(SCORE_MAX) : 10'(sc);
  end

  always_comb begin : collision
    int by, px, gy;
    by  = int'(bird_y_q);
    hit = (by + BIRD_H >= GROUND_Y);
    for (int unsigned k = 0; k < NP; k++) begin
      px = int'(pipe_x_q[k]);
      gy = int'(gap_y_q[k]);
      if ((px < BIRD_X + BIRD_W) && (px + PIPE_W > BIRD_X) &&
          ((by < gy) || (by + BIRD_H > gy + GAP_H)))
        hit = 1'b1;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    cnt_d    = cnt_q;
    flap_d   = flap_q;
    vel_d    = vel_q;
    bird_y_d = bird_y_q;
    score_d  = score_q;
    tick_d   = 1'b0;
    over_d   = 1'b0;
    for (int unsigned k = 0; k < NP; k++) begin
      pipe_x_d[k] = pipe_x_q[k];
      gap_y_d[k]  = gap_y_q[k];
    end
    if (iScreen == 2'd0) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      flap_d   = 1'b0;
      vel_d    = '0;
      bird_y_d = 10'(INIT_Y);
      score_d  = '0;
      for (int unsigned k = 0; k < NP; k++) begin
        pipe_x_d[k] = 12'(FIRST_X + int'(k) * PIPE_SPACING);
        gap_y_d[k]  = 10'(GAP_MIN + int'(iRandom[8*k +: 8]));
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (iScreen == 2'd1) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          // tick_q marks the cycle after an update: positions are fresh here.
          if (iScreen == 2'd2) begin
            state_d = S_DEAD;
          end else if (tick_q && hit) begin
            state_d = S_DEAD;
            over_d  = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            flap_d   = 1'b0;
            tick_d   = 1'b1;
            vel_d    = upd_vel;
            bird_y_d = upd_y;
            score_d  = upd_score;
            for (int unsigned k = 0; k < NP; k++) begin
              pipe_x_d[k] = upd_x[k];
              gap_y_d[k]  = upd_gap[k];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (iFlap) flap_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      flap_q   <= 1'b0;
      vel_q    <= '0;
      bird_y_q <= 10'(INIT_Y);
      score_q  <= '0;
      over_q   <= 1'b0;
      tick_q   <= 1'b0;
      for (int unsigned k = 0; k < NP; k++) begin
        pipe_x_q[k] <= 12'(FIRST_X + int'(k) * PIPE_SPACING);
        gap_y_q[k]  <= 10'(GAP_MIN);
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flap_q   <= flap_d;
      vel_q    <= vel_d;
      bird_y_q <= bird_y_d;
      score_q  <= score_d;
      over_q   <= over_d;
      tick_q   <= tick_d;
      for (int unsigned k = 0; k < NP; k++) begin
        pipe_x_q[k] <= pipe_x_d[k];
        gap_y_q[k]  <= gap_y_d[k];
      end
    end
  end

  assign oBirdY     = bird_y_q;
  assign oPipe1X    = pipe_x_q[0][10:0];
  assign oPipe2X    = pipe_x_q[1][10:0];
  assign oPipe3X    = pipe_x_q[2][10:0];
  assign oPipe1Y    = gap_y_q[0];
  assign oPipe2Y    = gap_y_q[1];
  assign oPipe3Y    = gap_y_q[2];
  assign oScore     = score_q;
  assign oGameOver  = over_q;
  assign oFrameTick = tick_q;

endmodule

// File: tb/tb_game_state_engine.sv
// Directed bench for game_state_engine with FRAME_DIV = 4: a flap/fall vector
// table plus hand-written sequences for ground, override, scoring and wrap.
module tb_game_state_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  scr;
  logic        flap;
  logic [31:0] rnd;
  logic [9:0]  bird_y;
  logic [10:0] p1x, p2x, p3x;
  logic [9:0]  p1y, p2y, p3y;
  logic [9:0]  score;
  logic        go, tick;

  int checks = 0;
  int failures = 0;
  int frames = 0;
  int go_count = 0;
  bit ok;

  typedef struct {
    int mode;   // 0 none, 1 one flap, 2 two flaps, 3 flap in the update cycle
    int exp_y;
  } vec_t;

  vec_t vecs [38];
  int   ys [25];

  always #5 clk = ~clk;

  game_state_engine #(.FRAME_DIV(4)) dut (
    .iClock    (clk),
    .iReset    (rst),
    .iScreen   (scr),
    .iFlap     (flap),
    .iRandom   (rnd),
    .oBirdY    (bird_y),
    .oPipe1X   (p1x),
    .oPipe2X   (p2x),
    .oPipe3X   (p3x),
    .oPipe1Y   (p1y),
    .oPipe2Y   (p2y),
    .oPipe3Y   (p3y),
    .oScore    (score),
    .oGameOver (go),
    .oFrameTick(tick)
  );

  function automatic int sx(input logic [10:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (tick) frames++;
    if (go) go_count++;
  endtask

  task automatic pulse_flap();
    flap = 1'b1;
    step();
    flap = 1'b0;
  endtask

  task automatic wait_tick(output bit got);
    int start;
    start = frames;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (frames != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("tick_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, g0, f0;

    vecs[0] = '{0, 217};
    vecs[1] = '{0, 219};
    vecs[2] = '{0, 222};
    vecs[3] = '{2, 215};
    vecs[4] = '{0, 209};
    vecs[5] = '{0, 204};
    vecs[6] = '{3, 197};
    for (int i = 7; i < 35; i++) vecs[i] = '{1, 204 - 7 * (i - 5)};
    vecs[35] = '{1, 0};
    vecs[36] = '{0, 1};
    vecs[37] = '{0, 3};

    // Reset values
    rst = 1'b1; scr = 2'd0; flap = 1'b0; rnd = '0;
    step(); step();
    check("rst_bird_y", int'(bird_y), 216);
    check("rst_p1x", sx(p1x), 640);
    check("rst_p2x", sx(p2x), 880);
    check("rst_p3x_bits", int'(p3x), 1120);
    check("rst_p1y", int'(p1y), 60);
    check("rst_p2y", int'(p2y), 60);
    check("rst_p3y", int'(p3y), 60);
    check("rst_score", int'(score), 0);
    check("rst_gameover", int'(go), 0);
    check("rst_tick", int'(tick), 0);
    rst = 1'b0;

    // IDLE gap loading, first-tick latency, frame period
    rnd = 32'h11223344;
    step();
    check("idle_p1y", int'(p1y), 128);
    check("idle_p2y", int'(p2y), 111);
    check("idle_p3y", int'(p3y), 94);
    scr = 2'd1;
    rnd = 32'hFFFFFFFF;
    lat = 0;
    do begin step(); lat++; end while (!tick && lat < 20);
    check("first_tick_latency", lat, 5);
    lat = 0;
    do begin step(); lat++; end while (!tick && lat < 20);
    check("tick_period", lat, 4);
    check("run_y_after_2", int'(bird_y), 219);
    check("run_p1y_held", int'(p1y), 128);
    check("run_p2y_held", int'(p2y), 111);
    check("run_p3y_held", int'(p3y), 94);

    // iScreen -> 0 in the update cycle: IDLE wins
    step(); step(); step();
    scr = 2'd0;
    step();
    check("idle_wins_tick", int'(tick), 0);
    check("idle_wins_y", int'(bird_y), 216);
    check("idle_wins_p1x", sx(p1x), 640);
    check("idle_wins_p1y", int'(p1y), 315);

    // Fall / flap / clamp vector table
    rnd = 32'h64646464;
    step();
    scr = 2'd1;
    for (int i = 0; i < 38; i++) begin
      if (vecs[i].mode == 3) begin
        step(); step(); step();
        flap = 1'b1;
        step();
        flap = 1'b0;
        check("late_flap_tick", int'(tick), 1);
      end else begin
        for (int p = 0; p < vecs[i].mode; p++) pulse_flap();
        wait_tick(ok);
      end
      check($sformatf("bird_y[%0d]", i), int'(bird_y), vecs[i].exp_y);
      check($sformatf("pipe1_x[%0d]", i), sx(p1x), 640 - 2 * (i + 1));
    end

    // Ground collision and freeze
    scr = 2'd0;
    step();
    scr = 2'd1;
    g0 = go_count;
    for (int f = 1; f <= 24; f++) begin
      wait_tick(ok);
      if (!ok) break;
      ys[f] = int'(bird_y);
    end
    check("fall_y9_capped", ys[9], 260);
    check("fall_y10_capped", ys[10], 268);
    check("fall_y23", ys[23], 372);
    check("fall_y24", ys[24], 380);
    check("ground_no_early_pulse", go_count - g0, 0);
    step();
    check("ground_gameover", int'(go), 1);
    step();
    check("ground_pulse_width", int'(go), 0);
    f0 = frames;
    repeat (20) step();
    check("dead_no_ticks", frames - f0, 0);
    check("dead_single_pulse", go_count - g0, 1);
    check("dead_y_frozen", int'(bird_y), 380);
    check("dead_p1x_frozen", sx(p1x), 592);

    // Screen override: RUN -> DEAD without pulse, then reload
    scr = 2'd0;
    step();
    scr = 2'd1;
    wait_tick(ok);
    wait_tick(ok);
    scr = 2'd2;
    g0 = go_count;
    f0 = frames;
    repeat (12) step();
    check("override_no_pulse", go_count - g0, 0);
    check("override_no_ticks", frames - f0, 0);
    check("override_y_frozen", int'(bird_y), 219);
    scr = 2'd1;
    repeat (8) step();
    check("override_stay_dead", frames - f0, 0);
    check("override_stay_y", int'(bird_y), 219);
    scr = 2'd0;
    step();
    check("override_reload_y", int'(bird_y), 216);
    check("override_reload_p1x", sx(p1x), 640);
    check("override_reload_score", int'(score), 0);

    // Scoring and pipe wrap
    rnd = 32'h64646464;
    step();
    scr = 2'd1;
    step();
    rnd = 32'h000000A5;
    g0 = go_count;
    for (int f = 1; f <= 346; f++) begin
      if (bird_y > 10'd230) pulse_flap();
      wait_tick(ok);
      if (!ok) break;
      if (f == 295) check("score_f295", int'(score), 0);
      if (f == 296) begin
        check("score_f296", int'(score), 1);
        check("p1x_f296", sx(p1x), 48);
      end
      if (f == 345) check("p1x_f345", sx(p1x), -50);
      if (f == 346) begin
        check("p1x_wrap", sx(p1x), 668);
        check("p1y_wrap", int'(p1y), 225);
        check("p2y_kept", int'(p2y), 160);
        check("p2x_f346", sx(p2x), 188);
        check("p3x_f346", sx(p3x), 428);
        check("score_f346", int'(score), 1);
      end
    end
    check("score_run_no_death", go_count - g0, 0);

    // Reset mid-frame
    step();
    rst = 1'b1;
    step();
    check("midrst_y", int'(bird_y), 216);
    check("midrst_p1x", sx(p1x), 640);
    check("midrst_p1y", int'(p1y), 60);
    check("midrst_score", int'(score), 0);
    check("midrst_tick", int'(tick), 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_state_engine.md
# game_state_engine

Frame-rate game-logic engine for the Flappy Bird datapath. It sits directly upstream of `game_render_controller` and drives its bird, pipe and score inputs. It integrates bird gravity and flap velocity once per video frame, scrolls and recycles three pipes with random gap heights, counts passed pipes, and detects collisions. The top-level uses its game-over pulse to advance `screen`.

## Interface
- `FRAME_DIV`, 833333: iClock cycles per frame tick (50 MHz / 60 Hz).
- `GRAVITY`, 1: px/frame² added to velocity.
- `FLAP_V`, 7: velocity set to −FLAP_V on flap.
- `MAX_FALL`, 8: maximum downward velocity.
- `PIPE_SPEED`, 2: px/frame pipe scroll.
- `PIPE_SPACING`, 240: px between consecutive pipes.
- `PIPE_W`, 52: pipe width in px.
- `GAP_H`, 120: gap height in px.
- `GAP_MIN`, 60: minimum gap top.
- `BIRD_X`, 100: fixed bird left edge.
- `BIRD_W`, 34: bird width in px.
- `BIRD_H`, 24: bird height in px.
- `GROUND_Y`, 400: ground line.
- `INIT_Y`, 216: initial bird top.
- `FIRST_X`, 640: initial X of pipe 1.

Ports:
- `iClock` in 1: system clock. One clock domain only.
- `iReset` in 1: synchronous, active-high reset.
- `iScreen` in 2: 0 = title, 1 = playing, 2 = game over.
- `iFlap` in 1: single-cycle flap request.
- `iRandom` in 32: free-running pseudo-random word.
- `oBirdY` out 10: bird top Y, unsigned.
- `oPipe1X`/`oPipe2X`/`oPipe3X` out 11 each: pipe left X, signed two's complement.
- `oPipe1Y`/`oPipe2Y`/`oPipe3Y` out 10 each: gap top Y, unsigned.
- `oScore` out 10: pipes passed, binary, saturating at 999.
- `oGameOver` out 1: one-cycle pulse on death.
- `oFrameTick` out 1: one-cycle pulse per frame update.

## Operation
- **State machine** with states IDLE, RUN and DEAD. All transitions are evaluated every cycle.
- **Reset values.** Reset forces IDLE and loads the init values:
  - bird Y = INIT_Y, velocity = 0, score = 0, flap-pending = 0, frame counter = 0.
  - Pipe k X (k = 1..3) = FIRST_X + (k−1)·PIPE_SPACING, giving 640, 880, 1120.
  - All gap Y = GAP_MIN.
  - oGameOver = 0, oFrameTick = 0.
- **IDLE.** While iScreen = 0, init values are reloaded every cycle, except gap Y, which becomes GAP_MIN + iRandom[8k−1:8(k−1)] for pipe k. iFlap is ignored.
- **IDLE → RUN** when iScreen = 1. Gap values hold as loaded on the last IDLE cycle.
- **RUN.**
  - iFlap sets flap-pending. The flag is consumed and cleared on the next frame update. Multiple flaps within one frame count as one.
  - The frame counter counts 0..FRAME_DIV−1. At wrap, one frame update executes.
- **Frame update (cycle U).**
  - Velocity: v' = flap-pending ? −FLAP_V : min(v + GRAVITY, MAX_FALL). v is signed 8-bit.
  - Bird Y: y' = y + v'. If y' < 0, then y' = 0 and v' = 0.
  - Pipes: each pipe X' = X − PIPE_SPEED. If X' ≤ −PIPE_W, then X' += 3·PIPE_SPACING and gap Y = GAP_MIN + iRandom[7:0].
  - Score: +1 per pipe whose right edge crosses the bird, i.e. X + PIPE_W > BIRD_X and X' + PIPE_W ≤ BIRD_X. Score saturates at 999.
- **Collision check (cycle U+1)**, on the updated values. A collision exists if either:
  - y + BIRD_H ≥ GROUND_Y, or
  - for any pipe, X < BIRD_X + BIRD_W and X + PIPE_W > BIRD_X, and (y < gapY or y + BIRD_H > gapY + GAP_H).
- **RUN → DEAD** on collision. oGameOver pulses for the cycle after the check.
- **DEAD.** All outputs frozen, no further pulses. Stays in DEAD while iScreen is 1 or 2.
- **Any state → IDLE** when iScreen = 0.
- **iScreen = 2 while in RUN:** go to DEAD with no oGameOver pulse.

## Timing
- All outputs are registered.
- oFrameTick is high in cycle U+1, together with the new positions.
- oGameOver is high in cycle U+2, and only when a collision is found.
- **Simultaneous events:**
  - iFlap in the same cycle as the tick: the flap is applied in this update.
  - iScreen → 0 in the same cycle as the tick: IDLE wins and no update occurs.
- **Reset mid-frame:** takes effect on the next edge, with all values returning to init.
- **Frame counter:** resets to 0 on IDLE → RUN, so the first update is FRAME_DIV cycles after entering RUN.

## Test plan
All scenarios use FRAME_DIV = 4.

- **Reset.** Hold iReset 2 cycles. Required: oBirdY = 216, pipe X = 640/880/1120, oScore = 0, oGameOver = 0.
- **Free fall.** iRandom = 0x64646464, iScreen 0→1, no flaps. After ticks 1/2/3: oBirdY = 217/219/222. Velocity caps at 8. With gap Y = 160, the bird bottom reaches 280 first, giving oGameOver exactly 1 cycle after that frame tick.
- **Flap.** After 3 falling ticks (y = 222), pulse iFlap. Next updates: y = 215, 209, 204. A flap at y = 3 clamps y to 0 with velocity 0.
- **Ground.** iRandom = 0x64646464 but gap placed away from the bird path, or pipes kept off screen. Falling reaches y ≥ 376, giving one oGameOver pulse and frozen outputs afterwards.
- **Score and wrap.** iRandom = 0x64646464; bench flaps whenever oBirdY > 230. oScore becomes 1 on frame 296 (pipe 1 X = 48). Pipe 1 X wraps from −50 to 668 on frame 346, with new gap Y = 60 + iRandom[7:0]. No oGameOver occurs.
- **Screen override.** In RUN, drive iScreen = 2: state goes to DEAD with no oGameOver pulse. Then iScreen = 0: init values reload within 1 cycle.
